fpu_result_reader: RTL and testbench
====================================

# fpu_result_reader

Reader at the output end of the `fpu` datapath. It watches the FPU result word (`{sign, exp[6], mant[25]}`, bias 31) and its 4-bit status until both are stable. It then converts the settled value to signed Q15.16 fixed point using a one-bit-per-cycle shifter. Each new result is presented once on a valid/ready handshake to downstream logic (display/UART).

## Interface
- `STABLE_CYCLES`, default 4: consecutive equal samples required before a word is accepted (≥2).
- `FRAC_BITS`, default 16: fractional bits of `res_fixed`; the 32-bit output is Q(31-FRAC_BITS).FRAC_BITS.
- `clock100KHz`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `data_in`  in  32  FPU result word.
- `status_in`  in  4  FPU status, one-hot: [3] EXACT, [2] OVERFLOW, [1] UNDERFLOW, [0] INEXACT.
- `res_valid`  out  1  converted result available.
- `res_ready`  in  1  consumer accepts the result on a cycle where `res_valid` and `res_ready` are both high.
- `res_fixed`  out  32  signed fixed-point result.
- `res_status`  out  4  `status_in` latched with the word.
- `res_sat`  out  1  result was saturated.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Stability detector:
  - `{data_in,status_in}` is registered every cycle.
  - Counter clears on any mismatch and increments (saturating) on a match.
  - A word is "settled" when the counter reaches STABLE_CYCLES-1.
- Acceptance rule: a settled word starts a conversion only in IDLE, and only if it differs from the last accepted word.
  - The first settled word after reset is always accepted, including all-zero.
- FSM states: IDLE → LOAD → SHIFT → FINISH → HOLD → IDLE.
  - LOAD: latch the word and status.
    - Exp==0 forces a zero result (mantissa ignored, no underflow saturation).
    - `status[2]` set forces saturation.
    - Either of these cases goes straight to FINISH.
    - Otherwise: mag = {1, mant} (26 bits), signed shift = exp − (56 − FRAC_BITS). Negative means right, positive means left. Go to SHIFT.
  - SHIFT: one bit position per cycle until the shift count reaches 0.
    - Right shift truncates toward zero.
    - If a left shift would set bit 31 of mag, set sat and go to FINISH immediately.
  - FINISH: apply sign.
    - Two's complement if sign=1.
    - On saturation: 0x7FFFFFFF if positive, 0x80000000 if negative; `res_sat`=1.
  - HOLD: `res_valid`=1. `res_fixed`/`res_status`/`res_sat` are held constant until the handshake, then return to IDLE.
- Input changes during LOAD/SHIFT/FINISH/HOLD are ignored. The detector keeps running, so a word that settled meanwhile is accepted on return to IDLE if it is new.
- A word that settles, changes, and returns to the last accepted value is not re-emitted.
- Reset mid-operation:
  - FSM goes to IDLE, counter clears, the "first word" flag is set.
  - In-flight data is discarded; no partial result is ever presented.

## Timing
- Reset values: `res_valid`=0, `res_fixed`=0, `res_status`=0, `res_sat`=0, `busy`=0.
- A new word sampled at edge k is settled at edge k+STABLE_CYCLES-1. IDLE→LOAD happens on that edge.
- Latency from LOAD entry to `res_valid` high:
  - Normal case: 1 (LOAD) + |shift| (SHIFT) + 1 (FINISH) cycles.
  - Zero or status overflow: 2 cycles.
  - Early saturation: fewer cycles.
- Worst case with FRAC_BITS=16: exp=1, right shift 39, 41 cycles.
- `res_valid` drops on the edge after the handshake. At least one IDLE cycle separates consecutive results.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared `fpu_pkg` holds:
  - field widths (SIGN=1, EXP_W=6, MANT_W=25), EXP_BIAS=31;
  - status bit indices;
  - the `reader_state_t` enum.
- The same package is reused by `fpu`.
- One sub-module: `fpu_stable_detect` (parameter STABLE_CYCLES; outputs `settled` and the registered word).
- The FSM and shifter stay in the top.

## Test plan
- +1 {0,31,0}, EXACT, held 20 cycles → after the settle delay plus 11 cycles, `res_fixed`=0x00010000, `res_sat`=0. Exactly one handshake.
- −2 {1,32,0} → 0xFFFE0000. With `res_ready` held low 30 cycles, outputs remain stable and `res_valid` stays high.
- Word toggling every 2 cycles (STABLE_CYCLES=4) → no conversion, `busy`=0. Then hold {0,33,0} → 0x00040000.
- Overflow {0,63,all-1s} with status 0100 → 0x7FFFFFFF, `res_sat`=1. Same mantissa with exp=46, status EXACT → early saturation, 0x7FFFFFFF.
- Zero word after reset → 0x00000000 emitted once. Re-applying the same zero later → no new `res_valid`. Exp=1, mant=1 → 0x00000000 after 41 cycles.
- `reset` low for 1 cycle during SHIFT → `busy`=0 and `res_valid`=0 next cycle. The held word is re-accepted as first after settling.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: result word layout, status bit positions and
// the result reader state encoding.
package fpu_pkg;
  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 6;
  localparam int MANT_W   = 25;
  localparam int WORD_W   = SIGN_W + EXP_W + MANT_W;
  localparam int STAT_W   = 4;
  localparam int EXP_BIAS = 31;

  localparam int ST_EXACT     = 3;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_INEXACT   = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fpu_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FINISH,
    S_HOLD
  } reader_state_t;
endpackage

// File: rtl/fpu_result_reader_if.sv
// FPU result input plus the fixed-point result handshake seen by consumers.
interface fpu_result_reader_if;
  import fpu_pkg::*;
  logic [WORD_W-1:0] data_in;
  logic [STAT_W-1:0] status_in;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_fixed;
  logic [STAT_W-1:0] res_status;
  logic              res_sat;
  logic              busy;

  modport master (
    output data_in, status_in, res_ready,
    input  res_valid, res_fixed, res_status, res_sat, busy
  );
  modport slave (
    input  data_in, status_in, res_ready,
    output res_valid, res_fixed, res_status, res_sat, busy
  );
endinterface

// File: rtl/fpu_stable_detect.sv
// Registers a sample every cycle and reports when it has been unchanged
// for STABLE_CYCLES consecutive samples.
module fpu_stable_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int W             = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sample,
  output logic [W-1:0] word,
  output logic         settled
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic [CW-1:0] cnt;
  logic          match;

  assign match = (sample == word);
  // True on the edge where the counter steps to STABLE_CYCLES-1, and after.
  assign settled = match && (cnt >= CW'(STABLE_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      word <= '0;
      cnt  <= '0;
    end else begin
      word <= sample;
      if (!match)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES - 1))
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fpu_result_reader.sv
// Waits for a settled FPU result, converts it to signed fixed point with a
// one-bit-per-cycle shifter and presents it once on a valid/ready handshake.
module fpu_result_reader
  import fpu_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAC_BITS     = 16
) (
  input logic                clock100KHz,
  input logic                reset,
  fpu_result_reader_if.slave bus
);
  localparam int SHIFT_OFS = EXP_BIAS + MANT_W - FRAC_BITS;

  logic [WORD_W+STAT_W-1:0] word_q, last_word;
  logic                     settled, first;
  reader_state_t            state;
  fpu_word_t                cur;
  logic [STAT_W-1:0]        cur_status;
  logic [31:0]              mag;
  logic [8:0]               cnt, shamt, shamt_abs;
  logic                     left, sat;
  logic                     valid_q, sat_q, busy_q;
  logic [31:0]              fixed_q;
  logic [STAT_W-1:0]        status_q;

  fpu_stable_detect #(.STABLE_CYCLES(STABLE_CYCLES), .W(WORD_W + STAT_W)) u_detect (
    .clk     (clock100KHz),
    .reset   (reset),
    .sample  ({bus.data_in, bus.status_in}),
    .word    (word_q),
    .settled (settled)
  );

  // Negative shamt means a right shift.
  assign shamt     = {3'b000, cur.exp} - 9'(SHIFT_OFS);
  assign shamt_abs = shamt[8] ? (9'd0 - shamt) : shamt;

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      state      <= S_IDLE;
      first      <= 1'b1;
      last_word  <= '0;
      cur        <= '0;
      cur_status <= '0;
      mag        <= '0;
      cnt        <= '0;
      left       <= 1'b0;
      sat        <= 1'b0;
      valid_q    <= 1'b0;
      fixed_q    <= '0;
      status_q   <= '0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (settled && (first || word_q != last_word)) begin
            first      <= 1'b0;
            last_word  <= word_q;
            cur        <= word_q[WORD_W+STAT_W-1:STAT_W];
            cur_status <= word_q[STAT_W-1:0];
            sat        <= 1'b0;
            busy_q     <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cur.exp == '0) begin
            mag   <= '0;
            state <= S_FINISH;
          end else if (cur_status[ST_OVERFLOW]) begin
            sat   <= 1'b1;
            state <= S_FINISH;
          end else begin
            mag   <= 32'({1'b1, cur.mant});
            left  <= ~shamt[8];
            cnt   <= shamt_abs;
            state <= (shamt == '0) ? S_FINISH : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (left && mag[30]) begin
            sat   <= 1'b1;
            state <= S_FINISH;
          end else begin
            mag <= left ? (mag << 1) : (mag >> 1);
            cnt <= cnt - 9'd1;
            if (cnt == 9'd1) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (sat) fixed_q <= cur.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          else     fixed_q <= cur.sign ? (32'd0 - mag) : mag;
          status_q <= cur_status;
          sat_q    <= sat;
          valid_q  <= 1'b1;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.res_valid  = valid_q;
  assign bus.res_fixed  = fixed_q;
  assign bus.res_status = status_q;
  assign bus.res_sat    = sat_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fpu_result_reader.sv
// Directed vector table plus hand-written handshake, stability and reset sequences.
module tb_fpu_result_reader;
  import fpu_pkg::*;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpu_result_reader_if bus();
  fpu_result_reader #(.STABLE_CYCLES(STABLE), .FRAC_BITS(16)) dut (
    .clock100KHz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  status;
    logic [31:0] fixed;
    logic        sat;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mkw(input logic s, input logic [5:0] e, input logic [24:0] m);
    return {s, e, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [3:0] s);
    bus.data_in   = w;
    bus.status_in = s;
  endtask

  task automatic wait_valid(output int cyc, input int limit);
    cyc = 0;
    while (!bus.res_valid && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake(input string name);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({name, "_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic quiet(input string name, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.res_valid || bus.busy) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] w33, w34;

    vecs[0]  = '{mkw(0, 31, 0),           4'b1000, 32'h0001_0000, 1'b0, 15};
    vecs[1]  = '{mkw(1, 32, 0),           4'b1000, 32'hFFFE_0000, 1'b0, 14};
    vecs[2]  = '{mkw(0, 33, 0),           4'b1000, 32'h0004_0000, 1'b0, 13};
    vecs[3]  = '{mkw(0, 63, 25'h1FFFFFF), 4'b0100, 32'h7FFF_FFFF, 1'b1, 6};
    vecs[4]  = '{mkw(0, 46, 25'h1FFFFFF), 4'b1000, 32'h7FFF_FFFF, 1'b1, 12};
    vecs[5]  = '{mkw(1, 46, 25'h1FFFFFF), 4'b1000, 32'h8000_0000, 1'b1, 12};
    vecs[6]  = '{mkw(1, 63, 0),           4'b0100, 32'h8000_0000, 1'b1, 6};
    vecs[7]  = '{mkw(0, 45, 25'h1FFFFFF), 4'b0001, 32'h7FFF_FFE0, 1'b0, 11};
    vecs[8]  = '{mkw(1, 31, 25'h1000000), 4'b0001, 32'hFFFE_8000, 1'b0, 15};
    vecs[9]  = '{mkw(0, 1, 1),            4'b0010, 32'h0000_0000, 1'b0, 45};
    vecs[10] = '{mkw(0, 0, 25'h1234567),  4'b0010, 32'h0000_0000, 1'b0, 6};
    vecs[11] = '{mkw(0, 40, 1),           4'b1000, 32'h0200_0001, 1'b0, 6};
    vecs[12] = '{mkw(0, 30, 3),           4'b0001, 32'h0000_8000, 1'b0, 16};
    vecs[13] = '{mkw(1, 30, 3),           4'b0001, 32'hFFFF_8000, 1'b0, 16};
    w33 = mkw(0, 33, 0);
    w34 = mkw(0, 34, 0);

    bus.res_ready = 1'b0;
    drive(vecs[0].word, vecs[0].status);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_valid",  32'(bus.res_valid), 32'd0);
    check("rst_fixed",  bus.res_fixed,      32'd0);
    check("rst_status", 32'(bus.res_status), 32'd0);
    check("rst_sat",    32'(bus.res_sat),   32'd0);
    check("rst_busy",   32'(bus.busy),      32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].word, vecs[i].status);
      wait_valid(cyc, 100);
      check($sformatf("v%0d_lat", i),    32'(cyc),            32'(vecs[i].lat));
      check($sformatf("v%0d_fixed", i),  bus.res_fixed,       vecs[i].fixed);
      check($sformatf("v%0d_sat", i),    32'(bus.res_sat),    32'(vecs[i].sat));
      check($sformatf("v%0d_status", i), 32'(bus.res_status), 32'(vecs[i].status));
      handshake($sformatf("v%0d", i));
    end

    // Held word is presented only once.
    quiet("hold_no_repeat", 30);

    // Backpressure; a word settling during HOLD is taken on return to IDLE.
    drive(mkw(1, 32, 0), 4'b1000);
    wait_valid(cyc, 100);
    check("bp_valid", 32'(bus.res_valid), 32'd1);
    drive(mkw(0, 35, 0), 4'b1000);
    begin
      int hits;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (!bus.res_valid || bus.res_fixed !== 32'hFFFE_0000 || bus.res_sat) hits++;
      end
      check("bp_stable", 32'(hits), 32'd0);
    end
    handshake("bp");
    wait_valid(cyc, 100);
    check("pend_lat",   32'(cyc),      32'd8);
    check("pend_fixed", bus.res_fixed, 32'h0010_0000);
    handshake("pend");

    // Toggling every 2 cycles never settles.
    begin
      int hits;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
        drive(mkw(0, 36 + 6'(i % 2), 0), 4'b1000);
        repeat (2) begin
          tick();
          if (bus.res_valid || bus.busy) hits++;
        end
      end
      check("toggle_idle", 32'(hits), 32'd0);
    end
    drive(w33, 4'b1000);
    wait_valid(cyc, 100);
    check("tog_lat",   32'(cyc),      32'd13);
    check("tog_fixed", bus.res_fixed, 32'h0004_0000);
    handshake("tog");

    // Brief excursion back to the last accepted word is not re-emitted.
    drive(w34, 4'b1000);
    repeat (2) tick();
    drive(w33, 4'b1000);
    quiet("return_no_emit", 20);

    // Zero word right after reset is emitted once.
    drive(32'd0, 4'b0000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_valid(cyc, 50);
    check("zero_valid", 32'(bus.res_valid), 32'd1);
    check("zero_fixed", bus.res_fixed,      32'd0);
    check("zero_sat",   32'(bus.res_sat),   32'd0);
    handshake("zero");
    drive(mkw(0, 2, 0), 4'b1000);
    repeat (2) tick();
    drive(32'd0, 4'b0000);
    quiet("zero_again", 20);

    // Reset during SHIFT discards the conversion; word is re-accepted as first.
    drive(mkw(0, 1, 1), 4'b0010);
    repeat (15) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    rst = 1'b1;
    wait_valid(cyc, 100);
    check("mid_lat",    32'(cyc),            32'd45);
    check("mid_fixed",  bus.res_fixed,       32'd0);
    check("mid_status", 32'(bus.res_status), 32'h2);
    handshake("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
